// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU control codes and the result-slot state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_XOR = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_ADD = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd5;
    localparam logic [3:0] ALU_MUL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_OR  = 4'd8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by all requesters; unknown control codes flag illegal and return 0.
module alu_core
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [3:0]        ctrl_i,
    output logic [DATA_W-1:0] result_o,
    output logic              illegal_o
);

    // SLL shifts by the whole data2 value, so oversize shifts naturally flush to zero.
    always_comb begin
        result_o  = '0;
        illegal_o = 1'b0;
        case (ctrl_i)
            ALU_AND: result_o = data1_i & data2_i;
            ALU_XOR: result_o = data1_i ^ data2_i;
            ALU_SLL: result_o = data1_i << data2_i;
            ALU_ADD: result_o = data1_i + data2_i;
            ALU_SUB: result_o = data1_i - data2_i;
            ALU_MUL: result_o = data1_i * data2_i;
            ALU_SRA: result_o = $signed(data1_i) >>> data2_i[4:0];
            ALU_OR:  result_o = data1_i | data2_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU with a single registered result slot.
// Define ALU_ARBITER_RR_EN for round-robin arbitration; default is fixed priority to requester 0.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREQ   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*DATA_W-1:0] req_data1_i,
    input  logic [NREQ*DATA_W-1:0] req_data2_i,
    input  logic [NREQ*4-1:0]      req_ctrl_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DATA_W-1:0]      rsp_data_o,
    output logic                   rsp_id_o,
    output logic                   rsp_err_o
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              id_q, id_d;
    logic              err_q, err_d;

    logic              slotOpen;
    logic              grantAny;
    logic              grantIdx;
    logic              preferIdx;
    logic [DATA_W-1:0] opA, opB, aluResult;
    logic [3:0]        opCtrl;
    logic              aluIllegal;

`ifdef ALU_ARBITER_RR_EN
    logic ptr_q, ptr_d;

    assign preferIdx = ptr_q;
    assign ptr_d     = grantAny ? ~grantIdx : ptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) ptr_q <= 1'b0;
        else       ptr_q <= ptr_d;
    end
`else
    assign preferIdx = 1'b0;
`endif

    // Grant depends only on valids, consumer readiness and state, never on operands.
    always_comb begin
        slotOpen    = (state_q == EMPTY) | rsp_ready_i;
        grantAny    = 1'b0;
        grantIdx    = 1'b0;
        req_ready_o = '0;
        if (!rst_i && slotOpen) begin
            if (req_valid_i[0] && req_valid_i[1]) begin
                grantAny = 1'b1;
                grantIdx = preferIdx;
            end else if (req_valid_i[0]) begin
                grantAny = 1'b1;
                grantIdx = 1'b0;
            end else if (req_valid_i[1]) begin
                grantAny = 1'b1;
                grantIdx = 1'b1;
            end
        end
        if (grantAny) req_ready_o[grantIdx] = 1'b1;
    end

    assign opA    = grantIdx ? req_data1_i[DATA_W +: DATA_W] : req_data1_i[0 +: DATA_W];
    assign opB    = grantIdx ? req_data2_i[DATA_W +: DATA_W] : req_data2_i[0 +: DATA_W];
    assign opCtrl = grantIdx ? req_ctrl_i[7:4] : req_ctrl_i[3:0];

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .data1_i   (opA),
        .data2_i   (opB),
        .ctrl_i    (opCtrl),
        .result_o  (aluResult),
        .illegal_o (aluIllegal)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        err_d   = err_q;
        if (grantAny) begin
            state_d = FULL;
            data_d  = aluResult;
            id_d    = grantIdx;
            err_d   = aluIllegal;
        end else if (state_q == FULL && rsp_ready_i) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            data_q  <= '0;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
            err_q   <= err_d;
        end
    end

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_data_o  = data_q;
    assign rsp_id_o    = id_q;
    assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected results, a monitor pops and compares.
module tb_alu_arbiter;

    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_i = 1'b1;
    logic [1:0]        req_valid_i = '0;
    logic [1:0]        req_ready_o;
    logic [63:0]       req_data1_i = '0;
    logic [63:0]       req_data2_i = '0;
    logic [7:0]        req_ctrl_i = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_id_o;
    logic              rsp_err_o;

    typedef struct {
        logic [31:0] data;
        logic        id;
        logic        err;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
`ifdef ALU_ARBITER_RR_EN
    int   modelPtr = 0;
`endif

    always #5 clk = ~clk;

    alu_arbiter #(
        .DATA_W (DATA_W),
        .NREQ   (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data1_i (req_data1_i),
        .req_data2_i (req_data2_i),
        .req_ctrl_i  (req_ctrl_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_err_o   (rsp_err_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference ALU written as plain arithmetic on wide integers.
    function automatic exp_t refAlu(input logic [31:0] a, input logic [31:0] b,
                                    input logic [3:0] c, input logic id);
        exp_t            r;
        longint unsigned ua = a;
        longint unsigned ub = b;
        longint          sa = $signed(a);
        longint          d;
        longint          q;
        r.id   = id;
        r.err  = 1'b0;
        r.data = '0;
        case (c)
            4'd1: r.data = a & b;
            4'd2: r.data = a ^ b;
            4'd3: r.data = (ub >= 32) ? 32'd0 : 32'(ua * (64'd1 << ub));
            4'd4: r.data = 32'(ua + ub);
            4'd5: r.data = 32'(ua - ub);
            4'd6: r.data = 32'(ua * ub);
            4'd7: begin
                d = longint'(64'd1 << (ub % 32));
                q = sa / d;
                if (sa < 0 && (sa % d) != 0) q = q - 1;
                r.data = 32'(q);
            end
            4'd8: r.data = a | b;
            default: begin
                r.data = '0;
                r.err  = 1'b1;
            end
        endcase
        return r;
    endfunction

    function automatic logic [31:0] randData();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 40));
            1:       return 32'h8000_0000 | 32'($urandom);
            default: return 32'($urandom);
        endcase
    endfunction

    // Drives one cycle of inputs and pushes the result the model expects to be accepted.
    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                                 input logic rr, input logic rst);
        bit          open;
        int          g;
        logic [1:0]  expReady;
        @(negedge clk);
        req_valid_i = v;
        req_data1_i = {a1, a0};
        req_data2_i = {b1, b0};
        req_ctrl_i  = {c1, c0};
        rsp_ready_i = rr;
        rst_i       = rst;
        #1;
        if (rst) begin
            checkOutput("ready_in_reset", {62'd0, req_ready_o}, 64'd0);
            expQ.delete();
`ifdef ALU_ARBITER_RR_EN
            modelPtr = 0;
`endif
        end else begin
            checkOutput("rsp_valid", {63'd0, rsp_valid_o}, {63'd0, expQ.size() != 0});
            open = (expQ.size() == 0) || rr;
            g = -1;
            if (open) begin
                if (v == 2'b11) begin
`ifdef ALU_ARBITER_RR_EN
                    g = modelPtr;
`else
                    g = 0;
`endif
                end else if (v[0]) begin
                    g = 0;
                end else if (v[1]) begin
                    g = 1;
                end
            end
            expReady = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
            checkOutput("req_ready", {62'd0, req_ready_o}, {62'd0, expReady});
            if (g == 0) expQ.push_back(refAlu(a0, b0, c0, 1'b0));
            if (g == 1) expQ.push_back(refAlu(a1, b1, c1, 1'b1));
`ifdef ALU_ARBITER_RR_EN
            if (g >= 0) modelPtr = (g == 0) ? 1 : 0;
`endif
        end
    endtask

    task automatic idle(input logic rr);
        applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, rr, 1'b0);
    endtask

    task automatic checkReset();
        @(posedge clk);
        #1;
        checkOutput("reset_valid", {63'd0, rsp_valid_o}, 64'd0);
        checkOutput("reset_data", {32'd0, rsp_data_o}, 64'd0);
        checkOutput("reset_id", {63'd0, rsp_id_o}, 64'd0);
        checkOutput("reset_err", {63'd0, rsp_err_o}, 64'd0);
    endtask

    // Monitor: while a result is presented it must match the queue head; a handshake retires it.
    always @(negedge clk) begin
        #2;
        if (!rst_i && rsp_valid_o) begin
            if (expQ.size() == 0) begin
                checkOutput("rsp_unexpected", {63'd0, rsp_valid_o}, 64'd0);
            end else begin
                checkOutput("rsp_data", {32'd0, rsp_data_o}, {32'd0, expQ[0].data});
                checkOutput("rsp_id", {63'd0, rsp_id_o}, {63'd0, expQ[0].id});
                checkOutput("rsp_err", {63'd0, rsp_err_o}, {63'd0, expQ[0].err});
                if (rsp_ready_i) void'(expQ.pop_front());
            end
        end
    end

    initial begin
        logic [1:0] v;
        logic [3:0] c0, c1;
        $display("[TB] starting alu_arbiter bench");
        applyStimulus(2'b11, 1, 1, 4, 2, 2, 4, 1'b1, 1'b1);
        applyStimulus(2'b11, 1, 1, 4, 2, 2, 4, 1'b1, 1'b1);
        checkReset();

        // single ADD, then SRA and SUB, then illegal codes
        applyStimulus(2'b01, 5, 3, 4, 0, 0, 0, 1'b1, 1'b0);
        idle(1'b1);
        applyStimulus(2'b01, 32'h8000_0000, 4, 7, 0, 0, 0, 1'b1, 1'b0);
        applyStimulus(2'b01, 3, 5, 5, 0, 0, 0, 1'b1, 1'b0);
        applyStimulus(2'b10, 0, 0, 0, 32'h1234, 32'h5678, 9, 1'b1, 1'b0);
        applyStimulus(2'b01, 32'hFFFF, 7, 0, 0, 0, 0, 1'b1, 1'b0);
        idle(1'b1);

        // contention for four cycles
        for (int i = 0; i < 4; i++)
            applyStimulus(2'b11, 10 + i, 1, 4, 20 + i, 1, 4, 1'b1, 1'b0);
        idle(1'b1);

        // backpressure: hold for three cycles, then drain and accept together
        applyStimulus(2'b01, 7, 6, 6, 0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            applyStimulus(2'b11, 1, 40, 3, 9, 2, 2, 1'b0, 1'b0);
        applyStimulus(2'b11, 1, 40, 3, 9, 2, 2, 1'b1, 1'b0);
        idle(1'b1);

        // reset while full, then contention must go to requester 0 first
        applyStimulus(2'b10, 0, 0, 0, 3, 4, 8, 1'b0, 1'b0);
        applyStimulus(2'b11, 1, 2, 4, 3, 4, 4, 1'b0, 1'b1);
        checkReset();
        applyStimulus(2'b11, 100, 1, 5, 200, 1, 5, 1'b1, 1'b0);
        applyStimulus(2'b11, 100, 2, 5, 200, 2, 5, 1'b1, 1'b0);
        idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            v  = 2'($urandom_range(0, 3));
            c0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            c1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            applyStimulus(v, randData(), randData(), c0, randData(), randData(), c1,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 59) == 0));
        end

        repeat (3) idle(1'b1);
        checkOutput("queue_drained", 64'(expQ.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL have parameter NREQ, default 2, number of requesters; only 2 supported.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 req_valid_i  input  2  per-requester operation valid; bit n = requester n.
REQ-006 req_ready_o  output  2  per-requester grant; transfer when valid&ready at a rising edge.
REQ-007 req_data1_i  input  2*DATA_W  operand 1; requester n in bits [n*DATA_W +: DATA_W].
REQ-008 req_data2_i  input  2*DATA_W  operand 2, same packing.
REQ-009 req_ctrl_i  input  8  4-bit ALU control per requester, [n*4 +: 4].
REQ-010 rsp_valid_o  output  1  result register holds a result.
REQ-011 rsp_ready_i  input  1  consumer accepts result when rsp_valid_o&rsp_ready_i.
REQ-012 rsp_data_o  output  DATA_W  result.
REQ-013 rsp_id_o  output  1  index of requester that issued the result.
REQ-014 rsp_err_o  output  1  control code was illegal (0 or 9-15).

Function
REQ-015 Control codes SHALL be: 1 AND, 2 XOR, 3 SLL, 4 ADD, 5 SUB, 6 MUL (low DATA_W bits), 7 SRA by data2[4:0], 8 OR.
REQ-016 SLL SHALL shift by the full data2 value; shift >= DATA_W yields 0.
REQ-017 Illegal codes SHALL produce rsp_data_o=0 and rsp_err_o=1; result still returned and handshaken.
REQ-018 Accept slot open SHALL be: !rsp_valid_o | rsp_ready_i.
REQ-019 At most one req_ready_o bit SHALL be high per cycle; none when slot closed or no req_valid_i.
REQ-020 req_ready_o SHALL depend combinationally on req_valid_i, rsp_ready_i and state only; no dependence on operands.
REQ-021 Only one requester valid and slot open: that requester SHALL be granted.
REQ-022 Both valid and slot open: grant SHALL follow the priority pointer (REQ-033/034).
REQ-023 Accepted op SHALL be computed combinationally and registered; rsp_valid_o high the cycle after acceptance (latency 1).
REQ-024 rsp_data_o, rsp_id_o, rsp_err_o SHALL hold stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-025 Drain and accept in same cycle SHALL keep rsp_valid_o=1 with new result next cycle (one op/cycle throughput).
REQ-026 Drain with no accept SHALL clear rsp_valid_o next cycle.
REQ-027 States: EMPTY (rsp_valid_o=0), FULL (rsp_valid_o=1); EMPTY->FULL on accept; FULL->EMPTY on drain without accept; otherwise hold.
REQ-028 A requester whose valid drops before grant SHALL lose nothing; no request is queued internally.

Reset
REQ-029 While rst_i=1 at a rising edge: rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_err_o=0, pointer=0, state EMPTY.
REQ-030 req_ready_o SHALL be 0 during any cycle rst_i=1.
REQ-031 Reset mid-operation SHALL discard a held result; no transfer counted in that cycle.

Configuration
REQ-032 Macro ALU_ARBITER_RR_EN SHALL select arbitration policy.
REQ-033 Defined: round-robin; pointer flips to the other requester after each grant made under contention or not; pointer holds when no grant.
REQ-034 Undefined: fixed priority, requester 0 always wins; pointer register absent.

Structure
REQ-035 Shared package alu_pkg SHALL hold ALU control code constants (1-8) and the EMPTY/FULL state type.
REQ-036 Computation SHALL live in one combinational sub-module alu_core (operands, ctrl in; result, illegal out); arbiter instantiates it once.

Verification
REQ-037 Single op: req0 valid, data1=5, data2=3, ctrl=4, rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_data_o=8, rsp_id_o=0, rsp_err_o=0.
REQ-038 SRA/SUB: data1=0x80000000, data2=4, ctrl=7 -> 0xF8000000; data1=3, data2=5, ctrl=5 -> 0xFFFFFFFE.
REQ-039 Contention, RR_EN defined: both valid 4 cycles, rsp_ready_i=1 -> rsp_id_o sequence 0,1,0,1; undefined -> 0,0,0,0.
REQ-040 Backpressure: result held with rsp_ready_i=0 for 3 cycles -> req_ready_o=0, outputs stable; on rsp_ready_i=1 new op accepted same cycle.
REQ-041 Illegal: ctrl=9 -> rsp_data_o=0, rsp_err_o=1; ctrl=0 same.
REQ-042 Reset: rst_i=1 while FULL -> next cycle rsp_valid_o=0, all outputs 0, first grant after reset goes to requester 0 under contention.
